table_key_search: RTL
=====================

// Module: table_key_search
// PURPOSE
//  Synthesizable sequential search engine over a small byte table. It accepts a key, then
//  scans the entries in order, one per cycle. Each non-matching entry is streamed downstream.
//  The scan stops at the first match ("break" semantics) and reports hit/index.
//  It sits between the key producer (upstream) and the result/log consumer (downstream).
// PARAMETERS
//  DEPTH   7  number of table entries (>=2); IDX_W = $clog2(DEPTH)
//  DATA_W  8  entry width, unsigned
//  KEY_W   4  key width (KEY_W <= DATA_W)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  wr_en      in   1       table write strobe
//  wr_addr    in   IDX_W   table write index; addr >= DEPTH is ignored
//  wr_data    in   DATA_W  table write data
//  key_valid  in   1       key offered
//  key_ready  out  1       high only in IDLE
//  key        in   KEY_W   search key
//  out_valid  out  1       non-matching entry available
//  out_ready  in   1       downstream accepts the entry
//  out_data   out  DATA_W  entry value
//  out_idx    out  IDX_W   entry index
//  done       out  1       one-cycle pulse: scan finished
//  hit        out  1       last scan found a match; held until next key accept
//  hit_idx    out  IDX_W   index of the match; 0 on miss; held like hit
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State=IDLE, idx=0.
//   - key_ready=1 after reset release; out_valid, done, hit and hit_idx are 0.
//   - Table entries reset to tbl[i]=i+1.
//   - Reset mid-scan aborts the scan with no done pulse.
//  Compare rule: match = ({(DATA_W-KEY_W){0},key_q} == tbl[idx]). Unsigned, zero-extended.
//  FSM IDLE -> SCAN -> DONE -> IDLE:
//   - IDLE:
//     - key_ready=1.
//     - On key_valid: latch key_q, idx<=0, clear hit/hit_idx, go SCAN.
//   - SCAN (out_* combinational from registered idx/table):
//     - Match: out_valid=0; hit<=1, hit_idx<=idx; go DONE.
//     - No match: out_valid=1, out_data=tbl[idx], out_idx=idx.
//     - If out_ready: if idx==DEPTH-1, go DONE with hit=0; else idx<=idx+1.
//     - If !out_ready: hold idx; out_data stable while stalled.
//   - DONE: done=1 for exactly one cycle; key_ready=0; next cycle go IDLE.
//  Latency (out_ready=1 throughout; accept cycle = 0):
//   - Match at index k: k entries streamed on cycles 1..k; done at cycle k+2.
//   - Miss: DEPTH entries streamed; done at cycle DEPTH+1.
//  Boundaries:
//   - Writes are accepted only in IDLE; wr_en in SCAN or DONE is dropped.
//   - A write and a key accept in the same IDLE cycle: the write lands first, so the scan
//     sees the new value.
//   - key_valid outside IDLE is not accepted (key_ready=0); the key producer must hold it.
//   - idx never exceeds DEPTH-1; no wrap.
//   - Duplicate matching entries: the lowest index wins.
// STRUCTURE
//  - Package table_search_pkg holds:
//    - typedef enum logic [1:0] {IDLE, SCAN, DONE} ts_state_e;
//    - default parameter constants;
//    - function ts_default(i) returning i+1.
//  - Sub-module table_search_regfile: DEPTH x DATA_W storage with async reset to defaults,
//    one write port and one combinational read port.
//  - The top level holds the FSM, idx counter, key_q and result registers.
// TESTING
//  1. Defaults, key=2, out_ready=1 -> out_data 1 (idx0); done at cycle 3; hit=1, hit_idx=1.
//  2. Defaults, key=0 -> out_data 1..7 on cycles 1..7; done at cycle 8; hit=0, hit_idx=0.
//  3. key=7, out_ready low on cycles 2-4 -> out_data 2 held stable while stalled.
//     Outputs 1..6 in order, then hit_idx=6.
//  4. Write tbl[3]=9 in IDLE, key=9 -> hit_idx=3.
//     Write during SCAN (tbl[5]=2) is dropped; tbl[5] reads back 6.
//  5. key_valid held high during SCAN -> key_ready=0; the second key is accepted the cycle
//     after done.
//  6. rst_n low mid-scan at idx 4 -> all outputs 0 immediately, table back to 1..7,
//     no done pulse.

Source files
------------

// File: rtl/table_search_pkg.sv
// Shared types and defaults for the table key search engine.
package table_search_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} ts_state_e;

  localparam int TS_DEPTH  = 7;
  localparam int TS_DATA_W = 8;
  localparam int TS_KEY_W  = 4;

  // Power-on contents of entry i.
  function automatic int unsigned ts_default(input int unsigned i);
    return i + 1;
  endfunction

endpackage

// File: rtl/table_search_regfile.sv
// DEPTH x DATA_W table: async reset to defaults, one write port, one combinational read port.
module table_search_regfile
  import table_search_pkg::*;
#(
  parameter int DEPTH  = TS_DEPTH,
  parameter int DATA_W = TS_DATA_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Addresses past the last entry are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(ts_default(i));
    end else if (we && int'(waddr) < DEPTH) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) rdata = mem[raddr];
  end

endmodule

// File: rtl/table_key_search.sv
// Sequential first-match key search: streams non-matching entries, stops on the first hit.
module table_key_search
  import table_search_pkg::*;
#(
  parameter int DEPTH  = TS_DEPTH,
  parameter int DATA_W = TS_DATA_W,
  parameter int KEY_W  = TS_KEY_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              done,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  ts_state_e         state;
  logic [IDX_W-1:0]  idx;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] rd_data;
  logic              match;

  // Writes only land while idle, so a scan always sees a frozen table.
  table_search_regfile #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en && state == IDLE),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx),
    .rdata (rd_data)
  );

  assign match     = (DATA_W'(key_q) == rd_data);
  assign out_valid = (state == SCAN) && !match;
  assign out_data  = out_valid ? rd_data : '0;
  assign out_idx   = out_valid ? idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      key_q     <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      done      <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (key_valid) begin
          key_q     <= key;
          idx       <= '0;
          hit       <= 1'b0;
          hit_idx   <= '0;
          key_ready <= 1'b0;
          state     <= SCAN;
        end
        SCAN: if (match) begin
          hit     <= 1'b1;
          hit_idx <= idx;
          done    <= 1'b1;
          state   <= DONE;
        end else if (out_ready) begin
          if (idx == LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          key_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
